// File: rtl/traffic_pkg.sv
// Shared encodings for the adaptive traffic-light controller: FSM states,
// per-phase light codes and a constant-friendly ceil(log2) helper.
package traffic_pkg;

  typedef enum logic [1:0] {
    ST_GREEN  = 2'd0,
    ST_YELLOW = 2'd1,
    ST_ALLRED = 2'd2
  } state_t;

  // Per-phase light code, bit order {red, yellow, green}
  localparam logic [2:0] LT_R = 3'b100;
  localparam logic [2:0] LT_Y = 3'b010;
  localparam logic [2:0] LT_G = 3'b001;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/phase_queue_counter.sv
// One approach's arrival counter: 2-flop detector synchroniser, rising-edge
// detect and a saturating count that the controller clears on green load.
module phase_queue_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             detect,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);

  logic [1:0]       sync_reg;
  logic             prev_reg;
  logic [CNT_W-1:0] count_reg;
  logic             arrival;

  assign arrival = sync_reg[1] & ~prev_reg;
  assign count   = count_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_reg  <= '0;
      prev_reg  <= 1'b0;
      count_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[0], detect};
      prev_reg <= sync_reg[1];
      // A car arriving on the clearing cycle belongs to the next service round
      if (clear) begin
        count_reg <= CNT_W'(arrival);
      end else if (arrival && (count_reg != {CNT_W{1'b1}})) begin
        count_reg <= count_reg + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/adaptive_phase_ctrl.sv
// N-approach adaptive traffic-light controller with demand-scaled green time.
// Define DEMAND_SKIP_EN to skip approaches with no queued cars.
module adaptive_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int N_PHASES    = 4,
  parameter int CNT_W       = 8,
  parameter int TW          = 6,
  parameter int MIN_GREEN   = 10,
  parameter int EXT_PER_CAR = 2,
  parameter int MAX_GREEN   = 40,
  parameter int YELLOW_T    = 4,
  parameter int ALLRED_T    = 2,
  localparam int PW         = clog2(N_PHASES)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      tick,
  input  logic [N_PHASES-1:0]       detect,
  output logic [3*N_PHASES-1:0]     lights,
  output logic [PW-1:0]             phase,
  output logic [1:0]                state,
  output logic [TW-1:0]             time_left,
  output logic [TW-1:0]             green_alloc,
  output logic [N_PHASES*CNT_W-1:0] queue_flat
);

  localparam int AW = CNT_W + TW + 1;

  state_t                  state_reg;
  logic [PW-1:0]           phase_reg;
  logic [TW-1:0]           time_reg;
  logic [TW-1:0]           alloc_reg;
  logic [3*N_PHASES-1:0]   lights_reg;

  logic [CNT_W-1:0]        queue [N_PHASES];
  logic [N_PHASES-1:0]     clear;
  logic                    load_green;
  logic [PW-1:0]           next_phase;
  logic [AW-1:0]           alloc_wide;
  logic [TW-1:0]           next_alloc;

  assign lights      = lights_reg;
  assign phase       = phase_reg;
  assign state       = state_reg;
  assign time_left   = time_reg;
  assign green_alloc = alloc_reg;

  assign load_green = tick && (state_reg == ST_ALLRED) && (time_reg == TW'(1));

  generate
    for (genvar gi = 0; gi < N_PHASES; gi++) begin : g_queue
      phase_queue_counter #(.CNT_W(CNT_W)) u_queue (
        .clk    (clk),
        .reset  (reset),
        .detect (detect[gi]),
        .clear  (clear[gi]),
        .count  (queue[gi])
      );
      assign clear[gi] = load_green && (next_phase == PW'(gi));
      assign queue_flat[gi*CNT_W +: CNT_W] = queue[gi];
    end
  endgenerate

  always_comb begin
    next_phase = (phase_reg == PW'(N_PHASES - 1)) ? '0 : phase_reg + PW'(1);
`ifdef DEMAND_SKIP_EN
    begin
      logic          found;
      logic [PW-1:0] cand;
      found = 1'b0;
      cand  = '0;
      // k == N_PHASES wraps to the current phase, so it is considered last
      for (int k = 1; k <= N_PHASES; k++) begin
        cand = PW'((int'(phase_reg) + k) % N_PHASES);
        if (!found && (queue[cand] != '0)) begin
          found      = 1'b1;
          next_phase = cand;
        end
      end
    end
`endif
  end

  always_comb begin
    alloc_wide = AW'(MIN_GREEN) + AW'(queue[next_phase]) * AW'(EXT_PER_CAR);
    next_alloc = (alloc_wide > AW'(MAX_GREEN)) ? TW'(MAX_GREEN) : alloc_wide[TW-1:0];
  end

  function automatic logic [3*N_PHASES-1:0] light_vec(input state_t st, input logic [PW-1:0] ph);
    logic [3*N_PHASES-1:0] v;
    v = {N_PHASES{LT_R}};
    for (int i = 0; i < N_PHASES; i++) begin
      if (PW'(i) == ph) begin
        if (st == ST_GREEN) v[3*i +: 3] = LT_G;
        else if (st == ST_YELLOW) v[3*i +: 3] = LT_Y;
      end
    end
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg  <= ST_ALLRED;
      phase_reg  <= PW'(N_PHASES - 1);
      time_reg   <= TW'(ALLRED_T);
      alloc_reg  <= '0;
      lights_reg <= {N_PHASES{LT_R}};
    end else if (tick) begin
      if (time_reg > TW'(1)) begin
        time_reg <= time_reg - TW'(1);
      end else begin
        case (state_reg)
          ST_GREEN: begin
            state_reg  <= ST_YELLOW;
            time_reg   <= TW'(YELLOW_T);
            lights_reg <= light_vec(ST_YELLOW, phase_reg);
          end
          ST_YELLOW: begin
            state_reg  <= ST_ALLRED;
            time_reg   <= TW'(ALLRED_T);
            lights_reg <= {N_PHASES{LT_R}};
          end
          default: begin
            state_reg  <= ST_GREEN;
            phase_reg  <= next_phase;
            time_reg   <= next_alloc;
            alloc_reg  <= next_alloc;
            lights_reg <= light_vec(ST_GREEN, next_phase);
          end
        endcase
      end
    end
  end

endmodule
